// File: rtl/dispatch_writeback_arbiter_pkg.sv
// dispatch_writeback_arbiter_pkg: shared GR file widths and the one-hot register decode
package dispatch_writeback_arbiter_pkg;
  localparam int GR_ADDR_W = 5;
  localparam int GR_DATA_W = 32;
  localparam int GR_NUM = 32;
  function automatic logic [GR_NUM-1:0] gr_onehot(input logic [GR_ADDR_W-1:0] a);
    return GR_NUM'(1) << a;
  endfunction
endpackage

// File: rtl/dispatch_writeback_arbiter_fifo.sv
// dispatch_writeback_fifo: per-source writeback queue exposing every slot's address for the pending decode
module dispatch_writeback_fifo
  import dispatch_writeback_arbiter_pkg::*;
#(
  parameter int P_DEPTH = 4,
  parameter int P_DEPTH_N = 2
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  input  logic iPUSH,
  input  logic [GR_ADDR_W-1:0] iADDR,
  input  logic [GR_DATA_W-1:0] iDATA,
  input  logic iPOP,
  output logic [GR_ADDR_W-1:0] oHEAD_ADDR,
  output logic [GR_DATA_W-1:0] oHEAD_DATA,
  output logic oFULL,
  output logic [P_DEPTH_N:0] oCOUNT,
  output logic [P_DEPTH-1:0] oENTRY_VALID,
  output logic [P_DEPTH*GR_ADDR_W-1:0] oENTRY_ADDR
);
  logic [GR_ADDR_W-1:0] addr_mem [P_DEPTH];
  logic [GR_DATA_W-1:0] data_mem [P_DEPTH];
  logic [P_DEPTH_N-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign oFULL = oCOUNT == (P_DEPTH_N+1)'(P_DEPTH);
  assign push = iPUSH && !oFULL;
  assign pop = iPOP && oCOUNT != '0;
  assign oHEAD_ADDR = addr_mem[rd_ptr];
  assign oHEAD_DATA = data_mem[rd_ptr];
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oCOUNT <= '0;
    end else if (iRESET_SYNC) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      oCOUNT <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      oCOUNT <= oCOUNT + (P_DEPTH_N+1)'(push) - (P_DEPTH_N+1)'(pop);
    end
  always_ff @(posedge iCLOCK)
    if (push && !iRESET_SYNC) begin
      addr_mem[wr_ptr] <= iADDR;
      data_mem[wr_ptr] <= iDATA;
    end
  // A slot is live when its distance from the read pointer is below the count
  for (genvar i = 0; i < P_DEPTH; i++) begin : g_entry
    logic [P_DEPTH_N-1:0] off;
    assign off = P_DEPTH_N'(i) - rd_ptr;
    assign oENTRY_VALID[i] = {1'b0, off} < oCOUNT;
    assign oENTRY_ADDR[i*GR_ADDR_W +: GR_ADDR_W] = addr_mem[i];
  end
endmodule

// File: rtl/dispatch_writeback_arbiter.sv
// dispatch_writeback_arbiter: merges ALU and LSU writebacks into one registered GR write port
module dispatch_writeback_arbiter
  import dispatch_writeback_arbiter_pkg::*;
#(
  parameter int P_DEPTH = 4,
  parameter int P_DEPTH_N = 2,
  parameter int P_STARVE = 3
) (
  input  logic iCLOCK,
  input  logic inRESET,
  input  logic iRESET_SYNC,
  input  logic iALU_VALID,
  input  logic [GR_ADDR_W-1:0] iALU_ADDR,
  input  logic [GR_DATA_W-1:0] iALU_DATA,
  output logic oALU_FULL,
  input  logic iLSU_VALID,
  input  logic [GR_ADDR_W-1:0] iLSU_ADDR,
  input  logic [GR_DATA_W-1:0] iLSU_DATA,
  output logic oLSU_FULL,
  output logic oWR_VALID,
  output logic [GR_ADDR_W-1:0] oWR_ADDR,
  output logic [GR_DATA_W-1:0] oWR_DATA,
  output logic [GR_NUM-1:0] oPENDING
);
  localparam int SW = $clog2(P_STARVE + 1);
  logic [GR_ADDR_W-1:0] alu_head_addr, lsu_head_addr;
  logic [GR_DATA_W-1:0] alu_head_data, lsu_head_data;
  logic [P_DEPTH_N:0] alu_count, lsu_count;
  logic [P_DEPTH-1:0] alu_entry_valid, lsu_entry_valid;
  logic [P_DEPTH*GR_ADDR_W-1:0] alu_entry_addr, lsu_entry_addr;
  logic [SW-1:0] starve_cnt, starve_nxt;
  logic alu_ne, lsu_ne, starved, pop_alu, pop_lsu;
  logic [GR_NUM-1:0] pending;
  dispatch_writeback_fifo #(.P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_alu_fifo (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPUSH(iALU_VALID), .iADDR(iALU_ADDR), .iDATA(iALU_DATA), .iPOP(pop_alu),
    .oHEAD_ADDR(alu_head_addr), .oHEAD_DATA(alu_head_data), .oFULL(oALU_FULL),
    .oCOUNT(alu_count), .oENTRY_VALID(alu_entry_valid), .oENTRY_ADDR(alu_entry_addr)
  );
  dispatch_writeback_fifo #(.P_DEPTH(P_DEPTH), .P_DEPTH_N(P_DEPTH_N)) u_lsu_fifo (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iRESET_SYNC(iRESET_SYNC),
    .iPUSH(iLSU_VALID), .iADDR(iLSU_ADDR), .iDATA(iLSU_DATA), .iPOP(pop_lsu),
    .oHEAD_ADDR(lsu_head_addr), .oHEAD_DATA(lsu_head_data), .oFULL(oLSU_FULL),
    .oCOUNT(lsu_count), .oENTRY_VALID(lsu_entry_valid), .oENTRY_ADDR(lsu_entry_addr)
  );
  // ALU has priority; the LSU is forced through once it has lost P_STARVE times in a row
  always_comb begin
    alu_ne = alu_count != '0;
    lsu_ne = lsu_count != '0;
    starved = starve_cnt == SW'(P_STARVE);
    pop_lsu = lsu_ne && (!alu_ne || starved);
    pop_alu = alu_ne && !pop_lsu;
    starve_nxt = (!lsu_ne || pop_lsu) ? '0 : starved ? starve_cnt : starve_cnt + 1'b1;
  end
  always_comb begin
    pending = oWR_VALID ? gr_onehot(oWR_ADDR) : '0;
    for (int k = 0; k < P_DEPTH; k++) begin
      if (alu_entry_valid[k]) pending |= gr_onehot(alu_entry_addr[k*GR_ADDR_W +: GR_ADDR_W]);
      if (lsu_entry_valid[k]) pending |= gr_onehot(lsu_entry_addr[k*GR_ADDR_W +: GR_ADDR_W]);
    end
  end
  assign oPENDING = pending;
  always_ff @(posedge iCLOCK or negedge inRESET)
    if (!inRESET) begin
      starve_cnt <= '0;
      oWR_VALID <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
    end else if (iRESET_SYNC) begin
      starve_cnt <= '0;
      oWR_VALID <= 1'b0;
      oWR_ADDR <= '0;
      oWR_DATA <= '0;
    end else begin
      starve_cnt <= starve_nxt;
      oWR_VALID <= pop_alu || pop_lsu;
      if (pop_alu || pop_lsu) begin
        oWR_ADDR <= pop_lsu ? lsu_head_addr : alu_head_addr;
        oWR_DATA <= pop_lsu ? lsu_head_data : alu_head_data;
      end
    end
endmodule
